// File: rtl/sbox_layer_pkg.sv
// Shared definitions for the nibble S-box layer: lookup tables and FSM encoding.
package sbox_layer_pkg;

  // PRESENT forward S-box, entry i at bits [4*i+3:4*i].
  localparam logic [63:0] SBOX_FWD = 64'h21748FE3DA09B65C;

  // Inverse of the PRESENT S-box, entry i at bits [4*i+3:4*i].
  localparam logic [63:0] SBOX_INV = 64'hA970364BD21C8FE5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sbox4_lut.sv
// Single 4-bit S-box lookup, forward or inverse selected by mode.
module sbox4_lut
  import sbox_layer_pkg::*;
(
  input  logic       mode,
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // Pure table lookup; mode 1 selects the inverse table.
  always_comb begin
    dout = SBOX_FWD[{din, 2'b00} +: 4];
    if (mode) begin
      dout = SBOX_INV[{din, 2'b00} +: 4];
    end
  end

endmodule

// File: rtl/sbox_layer.sv
// Iterative S-box layer: substitutes LANES nibbles per cycle over STEPS cycles,
// with a valid/ready handshake on both sides.
module sbox_layer
  import sbox_layer_pkg::*;
#(
  parameter int NIBBLES = 16,
  parameter int LANES   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   in_data,
  input  logic                   in_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   out_data,
  output logic                   busy
);

  localparam int STEPS  = NIBBLES / LANES;
  localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

  state_t                state_q, state_d;
  logic [4*NIBBLES-1:0]  data_q, data_d;
  logic [STEP_W-1:0]     step_q, step_d;
  logic                  mode_q, mode_d;

  logic [4*LANES-1:0]    lane_in;
  logic [4*LANES-1:0]    lane_out;

  // Select the group of nibbles addressed by the current step.
  always_comb begin
    lane_in = '0;
    for (int s = 0; s < STEPS; s++) begin
      if (step_q == STEP_W'(s)) begin
        lane_in = data_q[s*4*LANES +: 4*LANES];
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    sbox4_lut u_lut (
      .mode (mode_q),
      .din  (lane_in[4*l +: 4]),
      .dout (lane_out[4*l +: 4])
    );
  end

  // Next-state logic: accept in IDLE, substitute one lane group per BUSY cycle,
  // hold the result in DONE until the consumer takes it.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    step_d  = step_q;
    mode_d  = mode_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          mode_d  = in_mode;
          step_d  = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        for (int s = 0; s < STEPS; s++) begin
          if (step_q == STEP_W'(s)) begin
            data_d[s*4*LANES +: 4*LANES] = lane_out;
          end
        end
        // The counter holds on the final step so it never wraps mid-word.
        if (step_q == LAST_STEP) begin
          state_d = ST_DONE;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset discards any word in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      step_q  <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      step_q  <= step_d;
      mode_q  <= mode_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign out_data  = data_q;

endmodule

// File: tb/tb_sbox_layer.sv
// Directed bench for sbox_layer: default 4-lane build plus a single-cycle 16-lane build.
module tb_sbox_layer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_mode, out_ready;
  logic [63:0] in_data;
  logic        in_ready, out_valid, busy;
  logic [63:0] out_data;

  logic        o_in_valid, o_in_mode, o_out_ready;
  logic [63:0] o_in_data;
  logic        o_in_ready, o_out_valid, o_busy;
  logic [63:0] o_out_data;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  sbox_layer u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  sbox_layer #(.NIBBLES(16), .LANES(16)) u_one (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (o_in_valid),
    .in_ready  (o_in_ready),
    .in_data   (o_in_data),
    .in_mode   (o_in_mode),
    .out_valid (o_out_valid),
    .out_ready (o_out_ready),
    .out_data  (o_out_data),
    .busy      (o_busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Offer one word, then wait (bounded) for out_valid; lat counts edges after accept.
  task automatic send(input logic [63:0] d, input logic m, input bit toggle, output int lat);
    @(negedge clk);
    in_data  = d;
    in_mode  = m;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      if (toggle) begin
        in_mode = ~in_mode;
        in_data = ~in_data ^ 64'h5A5A_0F0F_3C3C_1234;
      end
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    int          lat;
    logic [63:0] held;

    rst_n = 1'b0;
    in_valid = 1'b0; in_mode = 1'b0; in_data = '0; out_ready = 1'b1;
    o_in_valid = 1'b0; o_in_mode = 1'b0; o_in_data = '0; o_out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_out_data",  out_data,       64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Forward substitution, 4-edge latency.
    send(64'h0123456789ABCDEF, 1'b0, 1'b0, lat);
    check("fwd_latency", 64'(lat), 64'd4);
    check("fwd_data", out_data, 64'hC56B90AD3EF84712);
    @(posedge clk); #1;
    check("fwd_released_valid", 64'(out_valid), 64'd0);
    check("fwd_released_ready", 64'(in_ready),  64'd1);

    // Inverse substitution.
    send(64'hC56B90AD3EF84712, 1'b1, 1'b0, lat);
    check("inv_latency", 64'(lat), 64'd4);
    check("inv_data", out_data, 64'h0123456789ABCDEF);
    @(posedge clk); #1;

    // Mixed pattern: all-zero word goes to all 'C'.
    send(64'h0000000000000000, 1'b0, 1'b0, lat);
    check("zero_data", out_data, 64'hCCCCCCCCCCCCCCCC);
    @(posedge clk); #1;

    // Backpressure in DONE.
    out_ready = 1'b0;
    send(64'h0123456789ABCDEF, 1'b0, 1'b0, lat);
    check("bp_latency", 64'(lat), 64'd4);
    held = 64'hC56B90AD3EF84712;
    for (int i = 0; i < 10; i++) begin
      check("bp_data",     out_data,        held);
      check("bp_valid",    64'(out_valid),  64'd1);
      check("bp_in_ready", 64'(in_ready),   64'd0);
      check("bp_busy",     64'(busy),       64'd1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_after_valid", 64'(out_valid), 64'd0);
    check("bp_after_ready", 64'(in_ready),  64'd1);

    // Reset after two BUSY edges discards the word.
    @(negedge clk);
    in_data = 64'h0123456789ABCDEF; in_mode = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid",    64'(out_valid), 64'd0);
    check("mid_rst_busy",     64'(busy),      64'd0);
    check("mid_rst_in_ready", 64'(in_ready),  64'd1);
    check("mid_rst_data",     out_data,       64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) lat++;
    end
    check("mid_rst_no_valid", 64'(lat), 64'd0);

    // Inputs changing during BUSY do not disturb the word in flight.
    send(64'h0123456789ABCDEF, 1'b0, 1'b1, lat);
    check("toggle_latency", 64'(lat), 64'd4);
    check("toggle_data", out_data, 64'hC56B90AD3EF84712);
    @(posedge clk); #1;

    // Fully parallel build completes one edge after accept.
    @(negedge clk);
    o_in_data = 64'hFFFFFFFFFFFFFFFF; o_in_mode = 1'b0; o_in_valid = 1'b1;
    @(posedge clk); #1;
    o_in_valid = 1'b0;
    lat = 0;
    while (!o_out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("par_latency", 64'(lat), 64'd1);
    check("par_data", o_out_data, 64'h2222222222222222);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/sbox_layer.md
SBOX_LAYER -- requirements
Module: sbox_layer

Interface
REQ-001 Parameter NIBBLES, default 16, SHALL set the number of 4-bit nibbles per data word; the data width is 4*NIBBLES.
REQ-002 Parameter LANES, default 4, SHALL set the number of nibbles substituted per clock; NIBBLES mod LANES = 0 is required.
REQ-003 The module SHALL derive STEPS = NIBBLES/LANES as a localparam.
REQ-004 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-005 rst_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-006 in_valid  input  1  SHALL indicate that in_data and in_mode are valid.
REQ-007 in_ready  output  1  SHALL indicate that the block can accept a word.
REQ-008 in_data  input  4*NIBBLES  SHALL carry the word to substitute.
REQ-009 in_mode  input  1  SHALL select the S-box: 0 = forward, 1 = inverse.
REQ-010 out_valid  output  1  SHALL indicate that out_data holds a completed result.
REQ-011 out_ready  input  1  SHALL indicate that the consumer accepts out_data.
REQ-012 out_data  output  4*NIBBLES  SHALL carry the substituted word.
REQ-013 busy  output  1  SHALL be high whenever the FSM is not in IDLE.

Function
REQ-014 The forward S-box SHALL map 0..F to C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2 (PRESENT).
REQ-015 The inverse S-box SHALL map 0..F to 5,E,F,8,C,1,2,D,B,4,6,3,0,7,9,A.
REQ-016 The FSM SHALL have exactly three states, IDLE, BUSY and DONE; in_ready = (state==IDLE) and out_valid = (state==DONE).
REQ-017 On an IDLE edge with in_valid high, the block SHALL load in_data into the data register, latch in_mode, clear the step counter and enter BUSY.
REQ-018 On each BUSY edge, the block SHALL replace nibbles [step*LANES .. step*LANES+LANES-1] with their S-box images using the latched mode, then increment step.
REQ-019 On the BUSY edge where step==STEPS-1, the FSM SHALL enter DONE; out_valid therefore rises exactly STEPS edges after the accept edge.
REQ-020 In DONE, out_data and out_valid SHALL hold stable until an edge with out_ready high, after which the FSM SHALL return to IDLE.
REQ-021 The block SHALL not accept a new word in the same cycle that it releases a result; in_ready rises one cycle after the output transfer.
REQ-022 Changes to in_mode or in_data after acceptance SHALL have no effect on the word in flight.
REQ-023 The step counter SHALL be max(1,clog2(STEPS)) bits wide and SHALL not wrap during a word.
REQ-024 With LANES==NIBBLES, the block SHALL complete in one BUSY cycle.

Reset
REQ-025 While rst_n is low, state SHALL be IDLE, the data register, step and mode SHALL be 0, and out_valid=0, busy=0, in_ready=1, out_data=0.
REQ-026 Reset asserted mid-word (BUSY or DONE) SHALL discard the word immediately; no out_valid SHALL follow release.

Structure
REQ-027 Package sbox_layer_pkg SHALL hold the forward and inverse 16-entry tables and the three-state FSM encoding.
REQ-028 Sub-module sbox4_lut (4-bit in, mode in, 4-bit out, combinational) SHALL be instantiated LANES times; the lane mux selects nibbles by step.

Verification
REQ-029 Default params, mode 0, in_data=64'h0123456789ABCDEF, out_ready=1 -> out_data=64'hC56B90AD3EF84712, with out_valid 4 edges after accept.
REQ-030 Mode 1, in_data=64'hC56B90AD3EF84712 -> out_data=64'h0123456789ABCDEF.
REQ-031 out_ready held low for 10 cycles in DONE -> out_data stable, in_ready=0, busy=1 throughout; in_ready=1 one cycle after the transfer.
REQ-032 rst_n pulsed low after 2 BUSY edges -> outputs as in REQ-025 at once; no out_valid within 20 cycles while in_valid is held low.
REQ-033 NIBBLES=16, LANES=16, mode 0, in_data=64'hFFFFFFFFFFFFFFFF -> out_data=64'h2222222222222222 one edge after accept.
REQ-034 Toggling in_mode and in_data every cycle during BUSY -> result equals the vector of REQ-029.
